// File: rtl/npu_definitions.sv
`default_nettype none
// ============================================================================
// Module : npu_definitions (package)
// Brief  : Shared NPU widths, activation selector and drain FSM states.
// Rev    : 1.0  initial release
// ============================================================================
package npu_definitions;

    localparam int ACC_WIDTH = 32;

    typedef enum logic [1:0] {
        ACT_NONE = 2'd0,
        ACT_RELU = 2'd1,
        ACT_GELU = 2'd2,
        ACT_TANH = 2'd3
    } activation_type_t;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } drain_state_t;

endpackage
`default_nettype wire

// File: rtl/acc_sat_add.sv
`default_nettype none
// ============================================================================
// Module : acc_sat_add
// Brief  : Combinational signed saturating adder (clamps to min/max).
// Rev    : 1.0  initial release
// ============================================================================
module acc_sat_add #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] sum_o
);

    localparam logic [WIDTH-1:0] C_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] C_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    logic [WIDTH-1:0] w_sum;
    logic             w_ovf;

    // Overflow only when both operands share a sign the wrapped sum lacks.
    assign w_sum = a_i + b_i;
    assign w_ovf = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (w_sum[WIDTH-1] != a_i[WIDTH-1]);
    assign sum_o = !w_ovf ? w_sum : (a_i[WIDTH-1] ? C_MIN : C_MAX);

endmodule
`default_nettype wire

// File: rtl/accumulator_drain.sv
`default_nettype none
// ============================================================================
// Module : accumulator_drain
// Brief  : Captures a row of accumulators and streams it one lane per cycle.
//          Optional per-lane saturating bias under macro ACC_DRAIN_BIAS_EN.
// Rev    : 1.0  initial release
// ============================================================================
module accumulator_drain #(
    parameter int ACC_WIDTH = npu_definitions::ACC_WIDTH,
    parameter int NUM_LANES = 16,
    parameter int LANE_W    = $clog2(NUM_LANES)
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                load_valid,
    output logic                                load_ready,
    input  logic [NUM_LANES*ACC_WIDTH-1:0]      load_data,
    input  logic                                load_last,
    input  npu_definitions::activation_type_t   load_act_type,
`ifdef ACC_DRAIN_BIAS_EN
    input  logic [NUM_LANES*ACC_WIDTH-1:0]      bias_data,
`endif
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [ACC_WIDTH-1:0]                out_data,
    output logic [LANE_W-1:0]                   out_lane,
    output logic                                out_last,
    output npu_definitions::activation_type_t   out_act_type,
    output logic                                busy
);

    import npu_definitions::*;

    localparam logic [LANE_W-1:0] C_LAST_LANE = LANE_W'(NUM_LANES - 1);

    drain_state_t           state_q;
    logic [LANE_W-1:0]      lane_q;
    logic                   last_q;
    logic [ACC_WIDTH-1:0]   out_data_q;
    logic                   out_last_q;
    activation_type_t       out_act_q;
    logic [ACC_WIDTH-1:0]   buf_q [NUM_LANES];
    logic [ACC_WIDTH-1:0]   row_d [NUM_LANES];

    logic                   w_final_hs;
    logic                   w_load;
    logic [LANE_W-1:0]      w_lane_nxt;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
`ifdef ACC_DRAIN_BIAS_EN
            acc_sat_add #(
                .WIDTH (ACC_WIDTH)
            ) u_sat_add (
                .a_i   (load_data[gi*ACC_WIDTH +: ACC_WIDTH]),
                .b_i   (bias_data[gi*ACC_WIDTH +: ACC_WIDTH]),
                .sum_o (row_d[gi])
            );
`else
            assign row_d[gi] = load_data[gi*ACC_WIDTH +: ACC_WIDTH];
`endif
        end
    endgenerate

    assign w_final_hs = (state_q == DRAIN) && (lane_q == C_LAST_LANE) && out_ready;
    assign load_ready = !rst && ((state_q == IDLE) || w_final_hs);
    assign w_load     = load_valid && load_ready;
    assign w_lane_nxt = lane_q + LANE_W'(1);

    // Row storage needs no reset: it is only observed after a fresh load.
    always_ff @(posedge clk) begin
        if (w_load) begin
            buf_q <= row_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            lane_q     <= '0;
            last_q     <= 1'b0;
            out_data_q <= '0;
            out_last_q <= 1'b0;
            out_act_q  <= ACT_NONE;
        end else if (w_load) begin
            state_q    <= DRAIN;
            lane_q     <= '0;
            last_q     <= load_last;
            out_data_q <= row_d[0];
            out_last_q <= 1'b0;
            out_act_q  <= load_act_type;
        end else if ((state_q == DRAIN) && out_ready) begin
            if (lane_q == C_LAST_LANE) begin
                state_q    <= IDLE;
                out_last_q <= 1'b0;
            end else begin
                lane_q     <= w_lane_nxt;
                out_data_q <= buf_q[w_lane_nxt];
                out_last_q <= last_q && (w_lane_nxt == C_LAST_LANE);
            end
        end
    end

    assign out_valid    = (state_q == DRAIN);
    assign busy         = (state_q == DRAIN);
    assign out_data     = out_data_q;
    assign out_lane     = lane_q;
    assign out_last     = out_last_q;
    assign out_act_type = out_act_q;

endmodule
`default_nettype wire

// File: tb/tb_accumulator_drain.sv
`default_nettype none
// ============================================================================
// Module : tb_accumulator_drain
// Brief  : Directed self-checking bench for accumulator_drain (16 x 32 bit).
// Rev    : 1.0  initial release
// ============================================================================
module tb_accumulator_drain;

    import npu_definitions::*;

    localparam int AW = 32;
    localparam int NL = 16;
    localparam int LW = 4;

    logic                 clk;
    logic                 rst;
    logic                 load_valid;
    logic                 load_ready;
    logic [NL*AW-1:0]     load_data;
    logic                 load_last;
    activation_type_t     load_act_type;
    logic                 out_valid;
    logic                 out_ready;
    logic [AW-1:0]        out_data;
    logic [LW-1:0]        out_lane;
    logic                 out_last;
    activation_type_t     out_act_type;
    logic                 busy;
`ifdef ACC_DRAIN_BIAS_EN
    logic [NL*AW-1:0]     bias_data;
`endif

    int n_checks;
    int n_errors;

    accumulator_drain #(
        .ACC_WIDTH (AW),
        .NUM_LANES (NL)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .load_valid    (load_valid),
        .load_ready    (load_ready),
        .load_data     (load_data),
        .load_last     (load_last),
        .load_act_type (load_act_type),
`ifdef ACC_DRAIN_BIAS_EN
        .bias_data     (bias_data),
`endif
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_lane      (out_lane),
        .out_last      (out_last),
        .out_act_type  (out_act_type),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [NL*AW-1:0] mk_row(input int base, input int step);
        logic [NL*AW-1:0] r;
        for (int i = 0; i < NL; i++) r[i*AW +: AW] = AW'(base + step * i);
        return r;
    endfunction

    initial begin
        logic [NL*AW-1:0] row;
        int stale;
        n_checks      = 0;
        n_errors      = 0;
        rst           = 1'b1;
        load_valid    = 1'b0;
        load_data     = '0;
        load_last     = 1'b0;
        load_act_type = ACT_NONE;
        out_ready     = 1'b0;
`ifdef ACC_DRAIN_BIAS_EN
        bias_data     = '0;
`endif
        tick();
        tick();
        @(negedge clk);
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_lane", out_lane, 0);
        chk("rst_last", out_last, 0);
        chk("rst_act", out_act_type, ACT_NONE);
        chk("rst_busy", busy, 0);
        chk("rst_ldrdy", load_ready, 0);

        // Single row: lanes 0..15, tile-last, ReLU
        tick();
        rst = 1'b0;
        load_valid = 1'b1; load_data = mk_row(0, 1); load_last = 1'b1;
        load_act_type = ACT_RELU; out_ready = 1'b1;
        @(negedge clk);
        chk("t1_ldrdy_idle", load_ready, 1);
        tick();
        load_valid = 1'b0;
        for (int b = 0; b < NL; b++) begin
            @(negedge clk);
            chk("t1_valid", out_valid, 1);
            chk("t1_data", out_data, b);
            chk("t1_lane", out_lane, b);
            chk("t1_last", out_last, (b == 15) ? 1 : 0);
            chk("t1_act", out_act_type, ACT_RELU);
            tick();
        end
        @(negedge clk);
        chk("t1_idle_valid", out_valid, 0);
        chk("t1_idle_busy", busy, 0);
        chk("t1_idle_ldrdy", load_ready, 1);

        // Back-to-back rows A (1000+i, GELU) and B (2000+i, TANH, last)
        tick();
        load_valid = 1'b1; load_data = mk_row(1000, 1); load_last = 1'b0;
        load_act_type = ACT_GELU;
        tick();
        load_data = mk_row(2000, 1); load_last = 1'b1; load_act_type = ACT_TANH;
        for (int b = 0; b < 2 * NL; b++) begin
            @(negedge clk);
            chk("t2_valid", out_valid, 1);
            chk("t2_data", out_data, (b < NL) ? 1000 + b : 2000 + b - NL);
            chk("t2_lane", out_lane, b % NL);
            chk("t2_last", out_last, (b == 31) ? 1 : 0);
            chk("t2_act", out_act_type, (b < NL) ? ACT_GELU : ACT_TANH);
            chk("t2_ldrdy", load_ready, (b % NL == 15) ? 1 : 0);
            tick();
            if (b == 15) load_valid = 1'b0;
        end
        @(negedge clk);
        chk("t2_idle", out_valid, 0);

        // Backpressure on lane 3 = -7
        tick();
        row = mk_row(0, 10);
        row[3*AW +: AW] = 32'hFFFF_FFF9;
        load_valid = 1'b1; load_data = row; load_last = 1'b0; load_act_type = ACT_RELU;
        tick();
        load_valid = 1'b0;
        for (int b = 0; b < 3; b++) begin
            @(negedge clk);
            tick();
        end
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("t3_hold_valid", out_valid, 1);
            chk("t3_hold_data", out_data, 32'hFFFF_FFF9);
            chk("t3_hold_lane", out_lane, 3);
            chk("t3_hold_ldrdy", load_ready, 0);
            tick();
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("t3_rel_lane", out_lane, 3);
        tick();
        @(negedge clk);
        chk("t3_next_data", out_data, 40);
        chk("t3_next_lane", out_lane, 4);
        for (int b = 4; b < NL; b++) tick();
        @(negedge clk);
        chk("t3_idle", busy, 0);

        // Reset mid-drain at lane 8
        tick();
        load_valid = 1'b1; load_data = mk_row(500, 1); load_last = 1'b1;
        tick();
        load_valid = 1'b0;
        for (int b = 0; b < 8; b++) begin
            @(negedge clk);
            tick();
        end
        @(negedge clk);
        chk("t4_lane8", out_data, 508);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("t4_valid", out_valid, 0);
        chk("t4_busy", busy, 0);
        chk("t4_ldrdy", load_ready, 1);
        chk("t4_data", out_data, 0);
        stale = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            @(negedge clk);
            if (out_valid) stale++;
        end
        chk("t4_no_stale", stale, 0);

        // Load while busy: row C drains, row D offered from lane 2
        tick();
        load_valid = 1'b1; load_data = mk_row(3000, 1); load_last = 1'b0;
        load_act_type = ACT_RELU;
        tick();
        load_valid = 1'b0;
        for (int b = 0; b < NL; b++) begin
            if (b == 2) begin
                load_valid = 1'b1; load_data = mk_row(4000, 2); load_last = 1'b1;
                load_act_type = ACT_NONE;
            end
            @(negedge clk);
            chk("t5_data", out_data, 3000 + b);
            chk("t5_ldrdy", load_ready, (b == 15) ? 1 : 0);
            tick();
        end
        load_valid = 1'b0;
        for (int b = 0; b < NL; b++) begin
            @(negedge clk);
            chk("t5d_valid", out_valid, 1);
            chk("t5d_data", out_data, 4000 + 2 * b);
            chk("t5d_lane", out_lane, b);
            chk("t5d_last", out_last, (b == 15) ? 1 : 0);
            chk("t5d_act", out_act_type, ACT_NONE);
            tick();
        end
        @(negedge clk);
        chk("t5_idle", busy, 0);

`ifdef ACC_DRAIN_BIAS_EN
        // Saturating bias
        row = '0;
        row[0*AW +: AW] = 32'h7FFF_FFF0;
        row[1*AW +: AW] = 32'h8000_0010;
        row[2*AW +: AW] = 32'd5;
        bias_data = '0;
        bias_data[0*AW +: AW] = 32'h0000_0100;
        bias_data[1*AW +: AW] = 32'hFFFF_FF00;
        bias_data[2*AW +: AW] = 32'hFFFF_FFFD;
        tick();
        load_valid = 1'b1; load_data = row; load_last = 1'b0;
        tick();
        load_valid = 1'b0;
        @(negedge clk);
        chk("t6_pos_sat", out_data, 32'h7FFF_FFFF);
        tick();
        @(negedge clk);
        chk("t6_neg_sat", out_data, 32'h8000_0000);
        tick();
        @(negedge clk);
        chk("t6_plain", out_data, 2);
        for (int b = 2; b < NL; b++) tick();
        bias_data = '0;
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
